// File: rtl/char_t.sv
// UART transmitter: 8N1 framing with a small input FIFO and per-frame baud latching.
// Line, done and busy outputs are registered one cycle behind the FSM state.
module char_t #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_baud,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [12:0]   cnt, cnt_nx, period, period_nx, baud_p;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          full, push, pop, last, tx_nx, done_nx, busy_nx;
  logic          unused_baud;

  assign unused_baud = ^i_baud[15:3];

  always_comb begin
    case (i_baud[2:0])
      3'd0:    baud_p = 13'd100;
      3'd1:    baud_p = 13'd200;
      3'd2:    baud_p = 13'd400;
      3'd3:    baud_p = 13'd600;
      3'd4:    baud_p = 13'd1200;
      3'd5:    baud_p = 13'd2400;
      default: baud_p = 13'd4800;
    endcase
  end

  // Full comes from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count == (AW+1)'(DEPTH));
  assign o_ready = !full && !i_rst;
  assign push    = i_valid && o_ready;
  assign last    = (cnt == period - 13'd1);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    period_nx  = period;
    pop        = 1'b0;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shift_nx  = mem[rd_ptr];
          period_nx = baud_p;
          cnt_nx    = '0;
          state_nx  = START;
        end
      end
      START: begin
        if (last) begin
          cnt_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = DATA;
        end else cnt_nx = cnt + 13'd1;
      end
      DATA: begin
        if (last) begin
          cnt_nx   = '0;
          shift_nx = shift >> 1;
          if (bit_idx == 3'd7) state_nx = STOP;
          else bit_idx_nx = bit_idx + 3'd1;
        end else cnt_nx = cnt + 13'd1;
      end
      STOP: begin
        if (last) begin
          done_nx = 1'b1;
          cnt_nx  = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count != '0) begin
            pop       = 1'b1;
            shift_nx  = mem[rd_ptr];
            period_nx = baud_p;
            state_nx  = START;
          end else state_nx = IDLE;
        end else cnt_nx = cnt + 13'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx_nx   = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
  assign busy_nx = (state != IDLE) || (count != '0);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      cnt     <= '0;
      period  <= '0;
      bit_idx <= '0;
      shift   <= '0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      period  <= period_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      o_tx    <= tx_nx;
      o_busy  <= busy_nx;
      o_done  <= done_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
